arf_pipe: RTL and testbench



---
 rtl/arf_pkg.sv | 46 ++++
 rtl/arf_mul_unit.sv | 23 ++
 rtl/arf_pipe.sv | 146 ++++++++++++++
 tb/tb_arf_pipe.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/arf_pkg.sv
// Shared constants for the auto-regressive filter datapath: widths, depth,
// coefficient slot map and reset values.
package arf_pkg;

  localparam int ARF_DATA_W   = 16;
  localparam int ARF_ACC_W    = 32;
  localparam int ARF_APPROX_K = 2;
  localparam int LAT          = 8;
  localparam int NUM_COEF     = 16;

  localparam int IDX_M1  = 0;
  localparam int IDX_M15 = 8;
  localparam int IDX_M16 = 9;
  localparam int IDX_M17 = 10;
  localparam int IDX_M18 = 11;
  localparam int IDX_M21 = 12;
  localparam int IDX_M22 = 13;
  localparam int IDX_M23 = 14;
  localparam int IDX_M24 = 15;

  localparam int COEF_POS = 3;
  localparam int COEF_NEG = -3;

  function automatic int coef_default(input int idx);
    return (idx >= IDX_M21 && idx <= IDX_M23) ? COEF_NEG : COEF_POS;
  endfunction

  function automatic int l4_idx(input int j);
    case (j)
      0:       return IDX_M15;
      1:       return IDX_M16;
      2:       return IDX_M17;
      default: return IDX_M18;
    endcase
  endfunction

  function automatic int l6_idx(input int j);
    case (j)
      0:       return IDX_M21;
      1:       return IDX_M22;
      2:       return IDX_M23;
      default: return IDX_M24;
    endcase
  endfunction

endpackage

// File: rtl/arf_mul_unit.sv
// Signed DATA_W x DATA_W multiplier, sign-extended to ACC_W; approximate mode
// clears the low APPROX_K bits of the data operand only.
module arf_mul_unit #(
  parameter int DATA_W   = 16,
  parameter int ACC_W    = 32,
  parameter int APPROX_K = 2
) (
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  input  logic                     approx,
  output logic signed [ACC_W-1:0]  p
);

  localparam logic [DATA_W-1:0] LSB_MASK = DATA_W'((1 << APPROX_K) - 1);

  logic signed [DATA_W-1:0]   a_eff;
  logic signed [2*DATA_W-1:0] prod;

  assign a_eff = approx ? (a & ~LSB_MASK) : a;
  assign prod  = a_eff * b;
  assign p     = ACC_W'(prod);

endmodule

// File: rtl/arf_pipe.sv
// Eight-level pipelined ARF dataflow graph, one DFG level per register stage,
// global stall, runtime coefficient file writable only while the pipe is empty.
module arf_pipe
  import arf_pkg::*;
#(
  parameter int DATA_W   = ARF_DATA_W,
  parameter int ACC_W    = ARF_ACC_W,
  parameter int APPROX_K = ARF_APPROX_K
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] x0,
  input  logic [DATA_W-1:0] x1,
  input  logic [DATA_W-1:0] x2,
  input  logic [DATA_W-1:0] x3,
  input  logic [DATA_W-1:0] x4,
  input  logic [DATA_W-1:0] x5,
  input  logic [DATA_W-1:0] x6,
  input  logic [DATA_W-1:0] x7,
  input  logic [ACC_W-1:0]  c13,
  input  logic [ACC_W-1:0]  c14,
  input  logic              approx_en,
  input  logic              coef_we,
  input  logic [3:0]        coef_addr,
  input  logic [DATA_W-1:0] coef_data,
  output logic              coef_busy,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  y27,
  output logic [ACC_W-1:0]  y28
);

  logic [LAT:1] vld_pipe;
  logic [5:1]   appr_pipe;
  logic [5:1]   old_pipe;
  logic         adv, coef_wr;

  logic [NUM_COEF-1:0][DATA_W-1:0] coef;
  logic [3:0]                      prev_addr;
  logic [DATA_W-1:0]               prev_data;

  logic [7:0][DATA_W-1:0] x_vec;
  logic [7:0][ACC_W-1:0]  l1_p, s1_p;
  logic [ACC_W-1:0]       s1_c13, s1_c14, s2_c13, s2_c14;
  logic [3:0][ACC_W-1:0]  s2_a;
  logic [7:3][1:0][ACC_W-1:0] dly;
  logic [DATA_W-1:0]      s3_a13, s3_a14, s5_a19, s5_a20;
  logic [3:0][ACC_W-1:0]  l4_m, s4_m, l6_m, s6_m;
  logic [ACC_W-1:0]       s7_a25, s7_a26;

  assign out_valid = vld_pipe[LAT];
  assign in_ready  = !vld_pipe[LAT] || out_ready;
  assign adv       = in_ready;
  assign coef_busy = |vld_pipe;
  assign coef_wr   = coef_we && !coef_busy;
  assign x_vec     = {x7, x6, x5, x4, x3, x2, x1, x0};

  // prev_* keeps the overwritten value so a sample accepted in the same cycle
  // as the write still sees the old coefficient at L4/L6.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_COEF; i++) coef[i] <= DATA_W'(coef_default(i));
      prev_addr <= '0;
      prev_data <= '0;
    end else if (coef_wr) begin
      coef[coef_addr] <= coef_data;
      prev_addr       <= coef_addr;
      prev_data       <= coef[coef_addr];
    end
  end

  for (genvar i = 0; i < 8; i++) begin : g_l1
    arf_mul_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .APPROX_K(APPROX_K)) u_mul (
      .a(x_vec[i]), .b(coef[IDX_M1+i]), .approx(approx_en), .p(l1_p[i])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_l4
    localparam int CI = l4_idx(j);
    logic [DATA_W-1:0] k;
    assign k = (old_pipe[3] && prev_addr == 4'(CI)) ? prev_data : coef[CI];
    arf_mul_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .APPROX_K(APPROX_K)) u_mul (
      .a((j % 2 == 0) ? s3_a13 : s3_a14), .b(k), .approx(appr_pipe[3]), .p(l4_m[j])
    );
  end

  for (genvar j = 0; j < 4; j++) begin : g_l6
    localparam int CI = l6_idx(j);
    logic [DATA_W-1:0] k;
    assign k = (old_pipe[5] && prev_addr == 4'(CI)) ? prev_data : coef[CI];
    arf_mul_unit #(.DATA_W(DATA_W), .ACC_W(ACC_W), .APPROX_K(APPROX_K)) u_mul (
      .a((j % 2 == 0) ? s5_a19 : s5_a20), .b(k), .approx(appr_pipe[5]), .p(l6_m[j])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_pipe  <= '0;
      appr_pipe <= '0;
      old_pipe  <= '0;
      s1_p      <= '0;
      s1_c13    <= '0;
      s1_c14    <= '0;
      s2_a      <= '0;
      s2_c13    <= '0;
      s2_c14    <= '0;
      dly       <= '0;
      s3_a13    <= '0;
      s3_a14    <= '0;
      s4_m      <= '0;
      s5_a19    <= '0;
      s5_a20    <= '0;
      s6_m      <= '0;
      s7_a25    <= '0;
      s7_a26    <= '0;
      y27       <= '0;
      y28       <= '0;
    end else if (adv) begin
      vld_pipe  <= {vld_pipe[LAT-1:1], in_valid};
      appr_pipe <= {appr_pipe[4:1], approx_en};
      old_pipe  <= {old_pipe[4:1], coef_wr};
      s1_p      <= l1_p;
      s1_c13    <= c13;
      s1_c14    <= c14;
      for (int k = 0; k < 4; k++) s2_a[k] <= s1_p[2*k] + s1_p[2*k+1];
      s2_c13    <= s1_c13;
      s2_c14    <= s1_c14;
      // a9/a12 ride alongside until the final adders
      dly[3]    <= {s2_a[3], s2_a[0]};
      for (int k = 4; k <= 7; k++) dly[k] <= dly[k-1];
      s3_a13    <= DATA_W'(s2_a[1] + s2_c13);
      s3_a14    <= DATA_W'(s2_a[2] + s2_c14);
      s4_m      <= l4_m;
      s5_a19    <= DATA_W'(s4_m[0] + s4_m[1]);
      s5_a20    <= DATA_W'(s4_m[2] + s4_m[3]);
      s6_m      <= l6_m;
      s7_a25    <= s6_m[0] + s6_m[1];
      s7_a26    <= s6_m[2] + s6_m[3];
      y27       <= dly[7][0] + s7_a25;
      y28       <= dly[7][1] + s7_a26;
    end
  end

endmodule

// File: tb/tb_arf_pipe.sv
// Randomized and directed bench for arf_pipe against an arithmetic DFG model
// with an in-order scoreboard.
module tb_arf_pipe;
  localparam int DW = 16;
  localparam int AW = 32;
  localparam int K  = 2;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, approx_en, coef_we, coef_busy;
  logic          out_valid, out_ready;
  logic [DW-1:0] x [8];
  logic [AW-1:0] c13, c14, y27, y28;
  logic [3:0]    coef_addr;
  logic [DW-1:0] coef_data;

  arf_pipe dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .x0(x[0]), .x1(x[1]), .x2(x[2]), .x3(x[3]),
    .x4(x[4]), .x5(x[5]), .x6(x[6]), .x7(x[7]),
    .c13(c13), .c14(c14), .approx_en(approx_en),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_busy(coef_busy), .out_valid(out_valid), .out_ready(out_ready),
    .y27(y27), .y28(y28)
  );

  typedef struct { int y27; int y28; int acc; } exp_t;
  exp_t q[$];
  int   mcoef[16];
  int   n_vec, n_err, cyc, inflight, n_out, last27, last28;
  bit   chk_lat;

  task automatic chk(input string tag, input longint got, input longint exp);
    n_vec++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d (cyc %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic void coef_reset();
    for (int i = 0; i < 16; i++) mcoef[i] = (i >= 12 && i <= 14) ? -3 : 3;
  endfunction

  function automatic int amul(input int d, input int c, input bit ap);
    shortint ds;
    ds = shortint'(d);
    if (ap) ds = ds & ~shortint'((1 << K) - 1);
    return int'(ds) * int'(shortint'(c));
  endfunction

  // DFG evaluated directly with 32-bit wrapping ints and 16-bit truncations
  function automatic exp_t ref_y(input int xs[8], input int c13v, input int c14v, input bit ap);
    int p[8];
    int a9, a10, a11, a12, a13, a14, m15, m16, m17, m18, a19, a20, m21, m22, m23, m24;
    exp_t r;
    for (int i = 0; i < 8; i++) p[i] = amul(xs[i], mcoef[i], ap);
    a9  = p[0] + p[1];  a10 = p[2] + p[3];
    a11 = p[4] + p[5];  a12 = p[6] + p[7];
    a13 = a10 + c13v;   a14 = a11 + c14v;
    m15 = amul(a13, mcoef[8], ap);  m16 = amul(a14, mcoef[9], ap);
    m17 = amul(a13, mcoef[10], ap); m18 = amul(a14, mcoef[11], ap);
    a19 = m15 + m16;    a20 = m17 + m18;
    m21 = amul(a19, mcoef[12], ap); m22 = amul(a20, mcoef[13], ap);
    m23 = amul(a19, mcoef[14], ap); m24 = amul(a20, mcoef[15], ap);
    r.y27 = a9 + m21 + m22;
    r.y28 = a12 + m23 + m24;
    r.acc = 0;
    return r;
  endfunction

  // Called at a negedge with inputs already driven; returns at the next negedge.
  task automatic step();
    bit   busy_m, fire_in, fire_out;
    exp_t e;
    int   xs[8];
    #1;
    busy_m = (inflight > 0);
    chk("coef_busy", coef_busy, busy_m);
    chk("in_ready", in_ready, !out_valid || out_ready);
    if (out_valid) begin
      if (q.size() == 0) chk("spurious_out_valid", 1, 0);
      else begin
        chk("y27", $signed(y27), q[0].y27);
        chk("y28", $signed(y28), q[0].y28);
      end
    end
    fire_out = out_valid && out_ready && (q.size() > 0);
    fire_in  = in_valid && (!out_valid || out_ready);
    if (fire_out) begin
      e = q.pop_front();
      if (chk_lat) chk("latency", cyc - e.acc, 8);
      last27 = $signed(y27);
      last28 = $signed(y28);
      n_out++;
    end
    if (fire_in) begin
      for (int i = 0; i < 8; i++) xs[i] = int'($signed(x[i]));
      e = ref_y(xs, $signed(c13), $signed(c14), approx_en);
      e.acc = cyc;
      q.push_back(e);
    end
    if (coef_we && !busy_m) mcoef[coef_addr] = int'($signed(coef_data));
    inflight += int'(fire_in) - int'(fire_out);
    @(posedge clk);
    cyc++;
    @(negedge clk);
  endtask

  task automatic idle_in();
    in_valid = 0; approx_en = 0; coef_we = 0; coef_addr = '0; coef_data = '0;
    c13 = '0; c14 = '0;
    for (int i = 0; i < 8; i++) x[i] = '0;
  endtask

  task automatic send(input int xv, input int c13v, input bit ap);
    for (int i = 0; i < 8; i++) x[i] = DW'(xv);
    c13 = AW'(c13v); c14 = '0; approx_en = ap; in_valid = 1;
    step();
    in_valid = 0; approx_en = 0;
  endtask

  task automatic drain(input int n);
    idle_in();
    out_ready = 1;
    repeat (n) step();
  endtask

  task automatic wr_coef(input int a, input int d);
    coef_we = 1; coef_addr = 4'(a); coef_data = DW'(d);
    step();
    coef_we = 0;
  endtask

  initial begin
    int n0;
    n_vec = 0; n_err = 0; cyc = 0; inflight = 0; n_out = 0; chk_lat = 0;
    idle_in();
    out_ready = 1;
    coef_reset();
    #1;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_y27", y27, 0);
    chk("rst_y28", y28, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_coef_busy", coef_busy, 0);
    @(negedge clk);
    rst_n = 1;

    chk_lat = 1;
    send(5, 0, 0); drain(10);
    chk("exact5_y27", last27, -1050);
    chk("exact5_y28", last28, 30);
    send(5, 0, 1); drain(10);
    chk("approx5_y27", last27, -840);
    chk("approx5_y28", last28, 24);
    chk_lat = 0;

    // fill all 8 stages, then back-pressure for 3 cycles
    n0 = n_out;
    for (int i = 0; i < 8; i++) send(1, i, 0);
    out_ready = 0;
    repeat (3) begin
      #1 chk("stall_in_ready", in_ready, 0);
      step();
    end
    drain(12);
    chk("stall_count", n_out - n0, 8);
    chk("stall_last_y27", last27, -336);
    chk("stall_last_y28", last28, 6);

    wr_coef(15, 16'hFFFD);
    send(5, 0, 0); drain(10);
    chk("c15_y27", last27, -1050);
    chk("c15_y28", last28, -1050);

    send(5, 0, 0);
    wr_coef(0, 0);
    drain(10);
    send(5, 0, 0); drain(10);
    chk("busy_wr_ignored_y27", last27, -1050);

    // write and sample together while idle: sample keeps the old coefficient
    coef_we = 1; coef_addr = 4'd8; coef_data = 16'd5;
    send(5, 0, 0);
    coef_we = 0;
    drain(10);
    chk("same_cyc_old_y27", last27, -1050);
    send(5, 0, 0); drain(10);
    chk("same_cyc_new_y27", last27, -1230);
    chk("same_cyc_new_y28", last28, -1230);

    wr_coef(0, 7);
    for (int i = 0; i < 9; i++) send(1, 0, 0);
    #2 rst_n = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_coef_busy", coef_busy, 0);
    chk("midrst_y27", y27, 0);
    chk("midrst_in_ready", in_ready, 1);
    q.delete(); inflight = 0; coef_reset();
    @(posedge clk); cyc++;
    @(negedge clk);
    rst_n = 1;
    send(1, 0, 0); drain(10);
    chk("postrst_y27", last27, -210);
    chk("postrst_y28", last28, 6);

    for (int blk = 0; blk < 6; blk++) begin
      int pv;
      pv = (blk % 2 == 0) ? 90 : 15;
      for (int n = 0; n < 100; n++) begin
        in_valid  = ($urandom_range(0, 99) < pv);
        out_ready = ($urandom_range(0, 3) != 0);
        for (int i = 0; i < 8; i++) x[i] = DW'($urandom);
        c13 = $urandom; c14 = $urandom;
        approx_en = $urandom_range(0, 1);
        coef_we   = ($urandom_range(0, 7) == 0);
        coef_addr = 4'($urandom_range(0, 15));
        coef_data = DW'($urandom);
        step();
      end
    end
    drain(40);
    chk("drain_empty", q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
